msi_bus_arbiter: RTL and testbench
==================================

MSI_BUS_ARBITER -- requirements
Module: msi_bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of cache controllers sharing the snoop bus (2..8).
REQ-002 Parameter ADDR_W, default 8, block address width.
REQ-003 Parameter WB_CYCLES, default 2, bus cycles reserved for a snooper write-back (>=1).
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  N_REQ  per-controller bus request, level.
REQ-007 req_msg  input  2*N_REQ  requester i message at [2i+1:2i]: 00 INVALIDATE, 01 WRITE_MISS, 10 READ_MISS, 11 error.
REQ-008 req_addr  input  ADDR_W*N_REQ  requester i block address at [ADDR_W*(i+1)-1:ADDR_W*i].
REQ-009 snoop_wb  input  N_REQ  snooper i holds the broadcast block MODIFIED and must write back.
REQ-010 grant  output  N_REQ  one-hot, owner of the current transaction.
REQ-011 done  output  N_REQ  one-hot, one-cycle completion pulse to the owner.
REQ-012 bus_valid  output  1  broadcast strobe; bus_msg/bus_addr/bus_src are valid while high.
REQ-013 bus_msg  output  2, bus_addr  output  ADDR_W, bus_src  output  $clog2(N_REQ)  broadcast fields.
REQ-014 wb_active  output  1  write-back window in progress.
REQ-015 err  output  1  one-cycle pulse on an error-coded request.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, BROADCAST, SNOOP, WRITEBACK, DONE; all outputs registered.
REQ-018 IDLE: if any req bit is set, the winner is chosen by round-robin starting at pointer ptr; its msg/addr/index are latched; next state BROADCAST; otherwise stay in IDLE.
REQ-019 Latched msg 11: skip BROADCAST/SNOOP; go directly to DONE with err pulsed in the DONE cycle and bus_valid never asserted.
REQ-020 BROADCAST (exactly 1 cycle): bus_valid=1 with latched fields; next SNOOP.
REQ-021 SNOOP (1 cycle): sample snoop_wb with the owner's bit masked; masked result is ignored for INVALIDATE; any set bit -> WRITEBACK, else DONE.
REQ-022 WRITEBACK: wb_active=1 for exactly WB_CYCLES cycles, counted by an internal down-counter; then DONE.
REQ-023 DONE (1 cycle): done[owner]=1; ptr <= (owner+1) mod N_REQ; next IDLE.
REQ-024 grant[owner] is high from BROADCAST through DONE inclusive, and 0 in IDLE.
REQ-025 Latency, from the edge at which IDLE samples req: bus_valid at +1, done at +3 without write-back, done at +3+WB_CYCLES with write-back.
REQ-026 Deassertion of req after latching is ignored; the transaction completes.
REQ-027 req still high in the IDLE cycle after done is a new request and is arbitrated normally.
REQ-028 snoop_wb outside the SNOOP cycle is ignored.
REQ-029 Simultaneous requests: exactly one grant; the others wait; no request starves (each waits at most N_REQ-1 transactions).

Reset
REQ-030 While reset is high at a clock edge: state=IDLE, ptr=0, WRITEBACK counter=0, all latched fields=0, and every output=0.
REQ-031 Reset during any state aborts the transaction without a done pulse.

Configuration
REQ-032 With MSI_ARB_FIXED_PRIO_EN defined, the lowest-index requester always wins and ptr is not implemented; without it, round-robin per REQ-018/REQ-023 applies.

Structure
REQ-033 Shared package msi_pkg: cache-state codes (INVALID 00, MODIFIED 01, SHARED 10), bus-message codes (BUS_INVALIDATE 00, BUS_WRITE_MISS 01, BUS_READ_MISS 10, error 11), and the arbiter FSM state enum.
REQ-034 Sub-module msi_rr_picker: combinational; inputs req and ptr; outputs a one-hot winner and its index.

Verification
REQ-035 Single request: req=0001, msg0=10, addr0=0x3C, no snoop_wb -> bus_valid at +1 with msg 10, addr 0x3C, src 0; done=0001 at +3.
REQ-036 Write-back: requester 2 sends WRITE_MISS, snoop_wb=0010 in the SNOOP cycle, WB_CYCLES=2 -> wb_active for 2 cycles, done=0100 at +5.
REQ-037 Round-robin: req=1111 held continuously -> grant order 0,1,2,3,0; with MSI_ARB_FIXED_PRIO_EN, every grant goes to 0.
REQ-038 Self mask: requester 1 sends READ_MISS with snoop_wb=0010 -> no WRITEBACK; done at +3.
REQ-039 Error message: msg3=11 -> no bus_valid; err and done=1000 pulse at +1.
REQ-040 Reset asserted during WRITEBACK -> next cycle all outputs 0, no done pulse, and the next request is granted from index 0.

Source files
------------

// File: rtl/msi_pkg.sv
// Shared MSI definitions: cache-line states, snoop-bus message codes and the
// bus arbiter FSM state encoding.
package msi_pkg;

    // Cache line state of an MSI controller.
    typedef enum logic [1:0] {
        CACHE_INVALID  = 2'b00,
        CACHE_MODIFIED = 2'b01,
        CACHE_SHARED   = 2'b10
    } cache_state_e;

    // Message broadcast on the snoop bus; 11 marks a malformed request.
    typedef enum logic [1:0] {
        BUS_INVALIDATE = 2'b00,
        BUS_WRITE_MISS = 2'b01,
        BUS_READ_MISS  = 2'b10,
        BUS_ERROR      = 2'b11
    } bus_msg_e;

    // Snoop bus arbiter sequencing.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_BROADCAST = 3'd1,
        ST_SNOOP     = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_DONE      = 3'd4
    } arb_state_e;

    // True when a requester presented the reserved error code.
    function automatic logic is_error(input bus_msg_e msg);
        return msg == BUS_ERROR;
    endfunction

endpackage

// File: rtl/msi_rr_picker.sv
// Combinational round-robin picker: scans req starting at index ptr and
// returns the first set bit as both a one-hot vector and an index.
module msi_rr_picker
    import msi_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_any
);

    // Rotate the search start to ptr and take the first requester found.
    always_comb begin
        int             cand;
        logic [IDX_W-1:0] cand_idx;
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        win_oh   = '0;
        win_idx  = '0;
        win_any  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!win_any && req[cand_idx]) begin
                win_any          = 1'b1;
                win_oh[cand_idx] = 1'b1;
                win_idx          = cand_idx;
            end
        end
    end

endmodule

// File: rtl/msi_bus_arbiter.sv
// MSI snoop bus arbiter: grants one cache controller at a time, broadcasts its
// message, samples snooper write-back requests, reserves a write-back window
// and pulses done to the owner.
// Build option: define MSI_ARB_FIXED_PRIO_EN for fixed lowest-index priority
// instead of round-robin (the rotating pointer is then not built).
module msi_bus_arbiter
    import msi_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 8,
    parameter int WB_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [2*N_REQ-1:0]         req_msg,
    input  logic [ADDR_W*N_REQ-1:0]    req_addr,
    input  logic [N_REQ-1:0]           snoop_wb,
    output logic [N_REQ-1:0]           grant,
    output logic [N_REQ-1:0]           done,
    output logic                       bus_valid,
    output logic [1:0]                 bus_msg,
    output logic [ADDR_W-1:0]          bus_addr,
    output logic [$clog2(N_REQ)-1:0]   bus_src,
    output logic                       wb_active,
    output logic                       err,
    output logic                       busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(WB_CYCLES + 1);

    // Transaction context
    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  owner_idx_q, owner_idx_d;
    logic [N_REQ-1:0]  owner_oh_q, owner_oh_d;
    bus_msg_e          msg_q, msg_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  wb_cnt_q, wb_cnt_d;

    // Registered outputs
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              bus_valid_q, bus_valid_d;
    logic [1:0]        bus_msg_q, bus_msg_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [IDX_W-1:0]  bus_src_q, bus_src_d;
    logic              wb_active_q, wb_active_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    // Arbitration
    logic [N_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [IDX_W-1:0]  pick_ptr;
    logic [N_REQ-1:0]  snoop_hit;

`ifdef MSI_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    assign pick_ptr = ptr_q;
`endif

    msi_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req     (req),
        .ptr     (pick_ptr),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .win_any (pick_any)
    );

    // A snooper never writes back to itself, so the owner's bit is dropped.
    assign snoop_hit = snoop_wb & ~owner_oh_q;

    // Next-state and next-output computation; outputs follow the next state so
    // they are registered yet aligned with the state they describe.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later statements see
        // earlier results; only the clocked block uses '<='.
        state_d     = state_q;
        owner_idx_d = owner_idx_q;
        owner_oh_d  = owner_oh_q;
        msg_d       = msg_q;
        addr_d      = addr_q;
        wb_cnt_d    = wb_cnt_q;
`ifndef MSI_ARB_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_idx_d = pick_idx;
                    owner_oh_d  = pick_oh;
                    msg_d       = bus_msg_e'(req_msg[{pick_idx, 1'b0} +: 2]);
                    addr_d      = req_addr[ADDR_W*pick_idx +: ADDR_W];
                    state_d     = is_error(msg_d) ? ST_DONE : ST_BROADCAST;
                end
            end
            ST_BROADCAST: begin
                state_d = ST_SNOOP;
            end
            ST_SNOOP: begin
                if ((msg_q != BUS_INVALIDATE) && (|snoop_hit)) begin
                    state_d  = ST_WRITEBACK;
                    wb_cnt_d = CNT_W'(WB_CYCLES - 1);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_WRITEBACK: begin
                if (wb_cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    wb_cnt_d = wb_cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
`ifndef MSI_ARB_FIXED_PRIO_EN
                ptr_d   = (owner_idx_q == IDX_W'(N_REQ - 1)) ? '0
                                                             : owner_idx_q + 1'b1;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d      = (state_d != ST_IDLE);
        grant_d     = busy_d ? owner_oh_d : '0;
        bus_valid_d = (state_d == ST_BROADCAST);
        bus_msg_d   = bus_valid_d ? msg_d : 2'b00;
        bus_addr_d  = bus_valid_d ? addr_d : '0;
        bus_src_d   = bus_valid_d ? owner_idx_d : '0;
        wb_active_d = (state_d == ST_WRITEBACK);
        done_d      = (state_d == ST_DONE) ? owner_oh_d : '0;
        err_d       = (state_d == ST_DONE) && is_error(msg_d);
    end

    // State, context and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the latched request fields are cleared too, so a reset
            // mid-transaction leaves no stale owner or message behind.
            state_q     <= ST_IDLE;
            owner_idx_q <= '0;
            owner_oh_q  <= '0;
            msg_q       <= BUS_INVALIDATE;
            addr_q      <= '0;
            wb_cnt_q    <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            bus_valid_q <= 1'b0;
            bus_msg_q   <= 2'b00;
            bus_addr_q  <= '0;
            bus_src_q   <= '0;
            wb_active_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
`ifndef MSI_ARB_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_idx_q <= owner_idx_d;
            owner_oh_q  <= owner_oh_d;
            msg_q       <= msg_d;
            addr_q      <= addr_d;
            wb_cnt_q    <= wb_cnt_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            bus_valid_q <= bus_valid_d;
            bus_msg_q   <= bus_msg_d;
            bus_addr_q  <= bus_addr_d;
            bus_src_q   <= bus_src_d;
            wb_active_q <= wb_active_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
`ifndef MSI_ARB_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign bus_valid = bus_valid_q;
    assign bus_msg   = bus_msg_q;
    assign bus_addr  = bus_addr_q;
    assign bus_src   = bus_src_q;
    assign wb_active = wb_active_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_msi_bus_arbiter.sv
// Scoreboard bench for msi_bus_arbiter: stimulus pushes expected broadcasts
// and completions; a negedge monitor pops and compares them as they appear.
module tb_msi_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int WB = 2;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [2*N-1:0]  req_msg;
    logic [AW*N-1:0] req_addr;
    logic [N-1:0]    snoop_wb;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            bus_valid;
    logic [1:0]      bus_msg;
    logic [AW-1:0]   bus_addr;
    logic [1:0]      bus_src;
    logic            wb_active;
    logic            err;
    logic            busy;

    logic [1:0]      msg_arr  [N];
    logic [AW-1:0]   addr_arr [N];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int wb_seen  = 0;

    typedef struct {
        logic [1:0]    msg;
        logic [AW-1:0] addr;
        int            src;
        int            cyc;
    } bus_exp_t;

    typedef struct {
        logic [N-1:0] done;
        logic         err;
        int           cyc;
        int           wb;
    } done_exp_t;

    bus_exp_t  bus_q  [$];
    done_exp_t done_q [$];
    bus_exp_t  be;
    done_exp_t de;

    msi_bus_arbiter #(
        .N_REQ     (N),
        .ADDR_W    (AW),
        .WB_CYCLES (WB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_msg   (req_msg),
        .req_addr  (req_addr),
        .snoop_wb  (snoop_wb),
        .grant     (grant),
        .done      (done),
        .bus_valid (bus_valid),
        .bus_msg   (bus_msg),
        .bus_addr  (bus_addr),
        .bus_src   (bus_src),
        .wb_active (wb_active),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_msg  = '0;
        req_addr = '0;
        for (int i = 0; i < N; i++) begin
            req_msg[2*i +: 2]   = msg_arr[i];
            req_addr[AW*i +: AW] = addr_arr[i];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a broadcast or completion.
    always @(negedge clk) begin
        if (bus_valid) begin
            if (bus_q.size() == 0) begin
                check("unexpected_bus_valid", 32'(bus_valid), 32'd0);
            end else begin
                be = bus_q.pop_front();
                check("bus_msg",   32'(bus_msg),  32'(be.msg));
                check("bus_addr",  32'(bus_addr), 32'(be.addr));
                check("bus_src",   32'(bus_src),  be.src);
                check("bus_cycle", cyc,           be.cyc);
                check("bus_grant", 32'(grant),    32'(1) << be.src);
            end
        end
        if (wb_active) wb_seen++;
        if (done != '0 || err) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                de = done_q.pop_front();
                check("done_vec",   32'(done),  32'(de.done));
                check("done_err",   32'(err),   32'(de.err));
                check("done_cycle", cyc,        de.cyc);
                check("wb_cycles",  wb_seen,    de.wb);
                check("done_grant", 32'(grant), 32'(de.done));
            end
        end
        if (!busy) wb_seen = 0;
    end

    task automatic check_all_zero(input string pfx);
        check({pfx, "_grant"},     32'(grant),     32'd0);
        check({pfx, "_done"},      32'(done),      32'd0);
        check({pfx, "_bus"},       32'({bus_valid, bus_msg, bus_addr, bus_src}), 32'd0);
        check({pfx, "_wb_active"}, 32'(wb_active), 32'd0);
        check({pfx, "_err"},       32'(err),       32'd0);
        check({pfx, "_busy"},      32'(busy),      32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one transaction from an idle bus; called and returns at a negedge
    // in an IDLE cycle. req is dropped right after sampling; snoop_wb carries
    // all-ones noise outside the SNOOP cycle.
    task automatic run_txn(input logic [N-1:0] rq, input int win, input logic [1:0] m,
                           input logic [AW-1:0] a, input logic [N-1:0] snp, input int wb);
        int s;
        int fin;
        msg_arr[win]  = m;
        addr_arr[win] = a;
        req = rq;
        @(posedge clk);
        #1;
        s = cyc;
        if (m == 2'b11) begin
            done_q.push_back('{done: N'(1) << win, err: 1'b1, cyc: s, wb: 0});
            fin = s + 1;
        end else begin
            bus_q.push_back('{msg: m, addr: a, src: win, cyc: s});
            done_q.push_back('{done: N'(1) << win, err: 1'b0, cyc: s + 2 + wb, wb: wb});
            fin = s + 3 + wb;
        end
        @(negedge clk);
        req      = '0;
        snoop_wb = '1;
        if (m != 2'b11) begin
            @(negedge clk);
            snoop_wb = snp;
            @(negedge clk);
            snoop_wb = '1;
        end
        while (cyc < fin) @(negedge clk);
        snoop_wb = '0;
    endtask

    initial begin
        int s0;
        reset    = 1'b1;
        req      = '0;
        snoop_wb = '0;
        for (int i = 0; i < N; i++) begin
            msg_arr[i]  = 2'b10;
            addr_arr[i] = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single READ_MISS from requester 0, no write-back
        run_txn(4'b0001, 0, 2'b10, 8'h3C, 4'b0000, 0);
        // WRITE_MISS from requester 2 with snooper 1 holding the block
        run_txn(4'b0100, 2, 2'b01, 8'hA5, 4'b0010, WB);
        // READ_MISS from requester 1: its own snoop_wb bit is masked
        run_txn(4'b0010, 1, 2'b10, 8'h11, 4'b0010, 0);
        // Error-coded message from requester 3
        run_txn(4'b1000, 3, 2'b11, 8'h5A, 4'b0000, 0);
        // INVALIDATE ignores snoop_wb
        run_txn(4'b0001, 0, 2'b00, 8'h77, 4'b1110, 0);

        // All four requesting continuously after a fresh reset
        do_reset();
        for (int i = 0; i < N; i++) begin
            msg_arr[i]  = 2'b10;
            addr_arr[i] = AW'(8'h40 + i);
        end
        req = 4'b1111;
        @(posedge clk);
        #1;
        s0 = cyc;
        for (int k = 0; k < 5; k++) begin
            int w;
`ifdef MSI_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = k % N;
`endif
            bus_q.push_back('{msg: 2'b10, addr: AW'(8'h40 + w), src: w, cyc: s0 + 4*k});
            done_q.push_back('{done: N'(1) << w, err: 1'b0, cyc: s0 + 4*k + 2, wb: 0});
        end
        while (cyc < s0 + 16) @(negedge clk);
        req = '0;
        while (cyc < s0 + 19) @(negedge clk);

        // Reset in the middle of a write-back window
        msg_arr[2]  = 2'b01;
        addr_arr[2] = 8'hC3;
        req = 4'b0100;
        @(posedge clk);
        #1;
        s0 = cyc;
        bus_q.push_back('{msg: 2'b01, addr: 8'hC3, src: 2, cyc: s0});
        @(negedge clk);
        req      = '0;
        snoop_wb = '1;
        @(negedge clk);
        snoop_wb = 4'b0010;
        @(negedge clk);
        snoop_wb = '0;
        check("wb_before_reset", 32'(wb_active), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        // Pointer must be back at 0: requesters 0 and 3 compete, 0 wins
        run_txn(4'b1001, 0, 2'b10, 8'h99, 4'b0000, 0);

        repeat (5) @(negedge clk);
        check("bus_q_empty",  bus_q.size(),  32'd0);
        check("done_q_empty", done_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
